// File: rtl/div_arbiter_if.sv
// Requester-side bundle of the divider arbiter: request handshake plus the tagged response.
// The arbiter takes the slave end; requesters (or a bench) take the master end.
interface div_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int NUM_W = 24,
  parameter int DEN_W = 16,
  parameter int Q_W   = 24
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*NUM_W-1:0] req_numer;
  logic [N_REQ*DEN_W-1:0] req_denom;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ-1:0]       resp_valid;
  logic [Q_W-1:0]         resp_quot;
  logic                   resp_dz;
  logic                   busy;

  modport slave (
    input  req_valid, req_numer, req_denom,
    output req_ready, resp_valid, resp_quot, resp_dz, busy
  );

  modport master (
    output req_valid, req_numer, req_denom,
    input  req_ready, resp_valid, resp_quot, resp_dz, busy
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined divider among N_REQ requesters.
// A tag pipeline tracks requester id and divide-by-zero alongside the divider.
module div_arbiter #(
  parameter int N_REQ       = 2,
  parameter int NUM_W       = 24,
  parameter int DEN_W       = 16,
  parameter int Q_W         = 24,
  parameter int DIV_LATENCY = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  div_arbiter_if.slave     bus,
  output logic [NUM_W-1:0] div_numer,
  output logic [DEN_W-1:0] div_denom,
  output logic             div_aclr,
  input  logic [Q_W-1:0]   div_quot
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int LAST = DIV_LATENCY;

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id);
    return (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] r;
    r = '0;
    r[id] = 1'b1;
    return r;
  endfunction

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant_id;
  logic [N_REQ-1:0] grant;
  logic             accept;
  logic [NUM_W-1:0] sel_numer;
  logic [DEN_W-1:0] sel_denom;
  logic             sel_dz;

  logic [LAST:0]    vld_p;
  logic [LAST:0]    dz_p;
  logic [ID_W-1:0]  id_p [LAST+1];

  always_comb begin
    grant    = '0;
    grant_id = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant == '0 && bus.req_valid[rr_index(ptr, k)]) begin
        grant[rr_index(ptr, k)] = 1'b1;
        grant_id                = rr_index(ptr, k);
      end
    end
    if (!rst_n) grant = '0;
  end

  assign accept        = |grant;
  assign bus.req_ready = grant;
  assign sel_numer     = bus.req_numer[int'(grant_id)*NUM_W +: NUM_W];
  assign sel_denom     = bus.req_denom[int'(grant_id)*DEN_W +: DEN_W];
  assign sel_dz        = (sel_denom == '0);
  assign div_aclr      = ~rst_n;
  assign bus.busy      = |vld_p;

  // ---- stage p0: operand registers toward the divider, pointer update ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      div_numer <= '0;
      div_denom <= DEN_W'(1);
    end else if (accept) begin
      ptr <= wrap_inc(grant_id);
      // a zero denominator is replaced by 0/1 so the divider never sees it
      div_numer <= sel_dz ? '0 : sel_numer;
      div_denom <= sel_dz ? DEN_W'(1) : sel_denom;
    end
  end

  // ---- stages p0..pLAST: tag pipeline, one slot per divider cycle ----
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p <= '0;
    else        vld_p <= {vld_p[LAST-1:0], accept};
  end

  always_ff @(posedge clk) begin
    dz_p     <= {dz_p[LAST-1:0], sel_dz};
    id_p[0]  <= grant_id;
    for (int k = 1; k <= LAST; k++) id_p[k] <= id_p[k-1];
  end

  // ---- response stage: align tag with the divider quotient ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.resp_valid <= '0;
      bus.resp_quot  <= '0;
      bus.resp_dz    <= 1'b0;
    end else begin
      bus.resp_valid <= vld_p[LAST] ? id_onehot(id_p[LAST]) : '0;
      bus.resp_dz    <= vld_p[LAST] & dz_p[LAST];
      bus.resp_quot  <= (vld_p[LAST] && !dz_p[LAST]) ? div_quot : '0;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: vector table for grants/operand registers, scoreboard for responses,
// plus contention, reset mid-flight and random-gap traffic against a behavioural divider.
module tb_div_arbiter;
  localparam int L = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] div_numer;
  logic [15:0] div_denom;
  logic        div_aclr;
  logic [23:0] div_quot;
  logic [23:0] qpipe [L];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  div_arbiter_if #(.N_REQ(2), .NUM_W(24), .DEN_W(16), .Q_W(24)) bus_if ();

  div_arbiter #(.N_REQ(2), .NUM_W(24), .DEN_W(16), .Q_W(24), .DIV_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if),
    .div_numer(div_numer), .div_denom(div_denom), .div_aclr(div_aclr), .div_quot(div_quot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural pipelined divider, L cycles from registered operands
  always @(posedge clk) begin
    if (div_aclr) begin
      for (int k = 0; k < L; k++) qpipe[k] <= '0;
    end else begin
      qpipe[0] <= (div_denom == 16'd0) ? 24'hFFFFFF : 24'(div_numer / div_denom);
      for (int k = 1; k < L; k++) qpipe[k] <= qpipe[k-1];
    end
  end
  assign div_quot = qpipe[L-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] ref_q(input logic [23:0] n, input logic [15:0] d);
    return (d == 16'd0) ? 24'd0 : 24'(n / d);
  endfunction

  typedef struct {
    int          due;
    logic [1:0]  id_oh;
    logic [23:0] quot;
    logic        dz;
  } sb_t;
  sb_t sbq [$];

  always @(negedge clk) begin
    sb_t         e;
    logic [1:0]  acc;
    logic [23:0] n;
    logic [15:0] d;
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (bus_if.resp_valid != 2'b00) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp_valid=%b expected none (cycle %0d)", bus_if.resp_valid, cyc);
        end else begin
          e = sbq.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(e.due));
          chk("resp_id", 64'(bus_if.resp_valid), 64'(e.id_oh));
          chk("resp_quot", 64'(bus_if.resp_quot), 64'(e.quot));
          chk("resp_dz", 64'(bus_if.resp_dz), 64'(e.dz));
        end
      end else begin
        chk("idle_quot", 64'(bus_if.resp_quot), 64'd0);
        chk("idle_dz", 64'(bus_if.resp_dz), 64'd0);
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
          e = sbq.pop_front();
          checks++; errors++;
          $display("FAIL missing_resp: got none expected id=%b due %0d (cycle %0d)", e.id_oh, e.due, cyc);
        end
      end
      acc = bus_if.req_valid & bus_if.req_ready;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          n = bus_if.req_numer[i*24 +: 24];
          d = bus_if.req_denom[i*16 +: 16];
          e.due   = cyc + L + 2;
          e.id_oh = 2'(1 << i);
          e.quot  = ref_q(n, d);
          e.dz    = (d == 16'd0);
          sbq.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [23:0] n0, input logic [15:0] d0,
                       input logic [23:0] n1, input logic [15:0] d1);
    bus_if.req_valid = v;
    bus_if.req_numer = {n1, n0};
    bus_if.req_denom = {d1, d0};
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [23:0] n0;
    logic [15:0] d0;
    logic [23:0] n1;
    logic [15:0] d1;
    logic [1:0]  rdy;
    logic [23:0] dnum;
    logic [15:0] dden;
  } vec_t;
  vec_t vecs [8];

  initial begin
    logic [1:0] acc;
    logic [1:0] v;
    logic [23:0] nn [2];
    logic [15:0] dd [2];

    vecs[0] = '{2'b00, 24'd0,     16'd0,   24'd0,        16'd0,     2'b00, 24'd0,        16'd1};
    vecs[1] = '{2'b01, 24'd1000,  16'd10,  24'd7,        16'd3,     2'b01, 24'd1000,     16'd10};
    vecs[2] = '{2'b11, 24'd77,    16'd7,   24'd90,       16'd9,     2'b10, 24'd90,       16'd9};
    vecs[3] = '{2'b11, 24'd65535, 16'd255, 24'd12,       16'd5,     2'b01, 24'd65535,    16'd255};
    vecs[4] = '{2'b01, 24'd300,   16'd0,   24'd1,        16'd1,     2'b01, 24'd0,        16'd1};
    vecs[5] = '{2'b10, 24'd5,     16'd5,   24'd500,      16'd0,     2'b10, 24'd0,        16'd1};
    vecs[6] = '{2'b10, 24'd5,     16'd5,   24'd16777215, 16'd65535, 2'b10, 24'd16777215, 16'd65535};
    vecs[7] = '{2'b00, 24'd9,     16'd9,   24'd9,        16'd9,     2'b00, 24'd16777215, 16'd65535};

    // reset state, with requests pending so the gating is visible
    drive(2'b11, 24'd10, 16'd2, 24'd20, 16'd4);
    tick(); tick();
    chk("rst_ready", 64'(bus_if.req_ready), 64'd0);
    chk("rst_busy", 64'(bus_if.busy), 64'd0);
    chk("rst_resp_valid", 64'(bus_if.resp_valid), 64'd0);
    chk("rst_resp_quot", 64'(bus_if.resp_quot), 64'd0);
    chk("rst_div_numer", 64'(div_numer), 64'd0);
    chk("rst_div_denom", 64'(div_denom), 64'd1);
    chk("rst_aclr", 64'(div_aclr), 64'd1);
    drive(2'b00, 24'd0, 16'd0, 24'd0, 16'd0);
    rst_n = 1'b1;
    tick();
    chk("run_aclr", 64'(div_aclr), 64'd0);

    // vector table: grant and operand register per cycle
    for (int r = 0; r < 8; r++) begin
      drive(vecs[r].valid, vecs[r].n0, vecs[r].d0, vecs[r].n1, vecs[r].d1);
      #1;
      chk($sformatf("vec%0d_ready", r), 64'(bus_if.req_ready), 64'(vecs[r].rdy));
      tick();
      chk($sformatf("vec%0d_div_numer", r), 64'(div_numer), 64'(vecs[r].dnum));
      chk($sformatf("vec%0d_div_denom", r), 64'(div_denom), 64'(vecs[r].dden));
    end
    drive(2'b00, 24'd0, 16'd0, 24'd0, 16'd0);
    repeat (L + 4) tick();

    // single request, exact latency by hand
    drive(2'b01, 24'd1000, 16'd10, 24'd0, 16'd0);
    tick();
    drive(2'b00, 24'd0, 16'd0, 24'd0, 16'd0);
    chk("single_busy", 64'(bus_if.busy), 64'd1);
    repeat (L) tick();
    chk("single_early", 64'(bus_if.resp_valid), 64'd0);
    tick();
    chk("single_valid", 64'(bus_if.resp_valid), 64'b01);
    chk("single_quot", 64'(bus_if.resp_quot), 64'd100);
    tick();
    chk("single_after", 64'(bus_if.resp_valid), 64'd0);
    chk("single_idle_busy", 64'(bus_if.busy), 64'd0);

    // contention from p=0
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(2'b11, 24'(1000 + 37*k), 16'(k + 1), 24'(5000 - 11*k), 16'(k + 3));
      #1;
      chk($sformatf("contend%0d_ready", k), 64'(bus_if.req_ready), (k % 2 == 0) ? 64'b01 : 64'b10);
      tick();
    end
    drive(2'b00, 24'd0, 16'd0, 24'd0, 16'd0);
    repeat (L + 4) tick();

    // reset while three requests are in flight
    drive(2'b01, 24'd111, 16'd3, 24'd0, 16'd0); tick();
    drive(2'b10, 24'd0, 16'd0, 24'd222, 16'd7); tick();
    drive(2'b01, 24'd333, 16'd0, 24'd0, 16'd0); tick();
    drive(2'b00, 24'd0, 16'd0, 24'd0, 16'd0);
    tick(); tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("flush_resp", 64'(bus_if.resp_valid), 64'd0);
      chk("flush_busy", 64'(bus_if.busy), 64'd0);
      tick();
    end
    drive(2'b11, 24'd1, 16'd1, 24'd1, 16'd1);
    #1;
    chk("flush_ptr", 64'(bus_if.req_ready), 64'b01);
    drive(2'b00, 24'd0, 16'd0, 24'd0, 16'd0);

    // random spacing and operands; a request holds its data until granted
    v = 2'b00;
    for (int i = 0; i < 2; i++) begin nn[i] = '0; dd[i] = '0; end
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      acc = bus_if.req_valid & bus_if.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !v[i]) begin
          v[i]  = ($urandom_range(0, 2) == 0);
          nn[i] = 24'($urandom);
          if ($urandom_range(0, 7) == 0)      dd[i] = 16'd0;
          else if ($urandom_range(0, 1) == 0) dd[i] = 16'($urandom_range(1, 300));
          else                                dd[i] = 16'($urandom_range(1, 65535));
        end
      end
      drive(v, nn[0], dd[0], nn[1], dd[1]);
    end
    drive(2'b00, 24'd0, 16'd0, 24'd0, 16'd0);
    repeat (L + 4) tick();
    chk("drain_queue", 64'(sbq.size()), 64'd0);
    chk("drain_busy", 64'(bus_if.busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, number of requesters sharing one pipelined divider (2..8).
REQ-002 Parameter NUM_W, default 24, numerator width.
REQ-003 Parameter DEN_W, default 16, denominator width.
REQ-004 Parameter Q_W, default 24, quotient width.
REQ-005 Parameter DIV_LATENCY, default 6, divider cycles from registered inputs to valid quotient (>=1).
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 rst_n  in  1  one clock; reset is synchronous and active-low.
REQ-008 req_valid  in  N_REQ  per-requester request strobe, held until accepted.
REQ-009 req_numer  in  N_REQ*NUM_W  packed numerators, slice i for requester i.
REQ-010 req_denom  in  N_REQ*DEN_W  packed denominators, slice i for requester i.
REQ-011 req_ready  out  N_REQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i].
REQ-012 div_numer  out  NUM_W  registered numerator to divider.
REQ-013 div_denom  out  DEN_W  registered denominator to divider.
REQ-014 div_aclr  out  1  divider clear; equals ~rst_n.
REQ-015 div_quot  in  Q_W  divider quotient.
REQ-016 resp_valid  out  N_REQ  one-cycle one-hot pulse identifying the requester owning resp_quot.
REQ-017 resp_quot  out  Q_W  quotient of the responding request.
REQ-018 resp_dz  out  1  high with resp_valid when that request had denominator 0.
REQ-019 busy  out  1  high while any accepted request is unanswered.

Function
REQ-020 At most one request SHALL be accepted per cycle; req_ready is combinational from req_valid and the round-robin pointer, at most one bit set, all zero when req_valid is zero.
REQ-021 Round-robin: search starts at pointer p; after granting i, p SHALL become (i+1) mod N_REQ; p unchanged on cycles without a grant; p=0 after reset.
REQ-022 On acceptance, div_numer/div_denom SHALL load the granted slices on that edge; otherwise they hold their previous value.
REQ-023 Zero denominator: div_denom SHALL load 1 and div_numer 0; the request's dz flag is carried in the tag pipeline.
REQ-024 A tag pipeline of DIV_LATENCY+1 stages (valid, requester id, dz) SHALL advance every cycle; stage 0 loads on acceptance, invalid otherwise.
REQ-025 Latency: request accepted at edge T SHALL produce resp_valid during the cycle following edge T+DIV_LATENCY+1; fixed, independent of traffic.
REQ-026 resp_quot SHALL equal div_quot when resp_valid is high and dz=0, 0 when dz=1, and 0 when no resp_valid.
REQ-027 Back-to-back acceptances every cycle SHALL yield back-to-back responses in acceptance order; no response is dropped or duplicated.
REQ-028 busy SHALL be the OR of all tag-pipeline valid bits.
REQ-029 Quotient width: no saturation; div_quot passed through unmodified (caller truncates, e.g. centroid_x = resp_quot[10:0]).
REQ-030 A requester SHALL NOT be granted while holding its request with changing data; arbiter samples data only on the grant cycle.

Reset
REQ-031 While rst_n=0 at an edge: tag pipeline cleared, p=0, div_numer=0, div_denom=1.
REQ-032 Outputs during/after reset: req_ready=0 (while rst_n=0), resp_valid=0, resp_quot=0, resp_dz=0, busy=0.
REQ-033 Reset mid-operation SHALL discard all in-flight requests; no resp_valid for any request accepted before reset.

Verification
REQ-034 Single request: N_REQ=2, req 0 numer=1000 denom=10 accepted at edge T -> resp_valid=2'b01, resp_quot=100 at cycle after T+7, busy low afterwards.
REQ-035 Contention: both req_valid high continuously, p=0 -> grants alternate 0,1,0,1; responses alternate in the same order, one per cycle.
REQ-036 Divide by zero: req 1 numer=500 denom=0 -> div_denom=1, resp_valid=2'b10, resp_dz=1, resp_quot=0.
REQ-037 Reset mid-flight: accept 3 requests, assert rst_n=0 for 1 cycle two cycles later -> no resp_valid for 10 cycles, busy=0, p=0.
REQ-038 Idle gaps: requests at random spacing with random operands -> every response matches the reference quotient, exact latency DIV_LATENCY+1, correct requester id.
